// File: rtl/core_sequencer_pkg.sv
// core_sequencer_pkg: shared encodings for the RV32E multi-cycle sequencer.
// Feature macro used by the sequencer: ILLEGAL_TRAP_EN.
package core_sequencer_pkg;

    typedef enum logic [6:0] {
        OPC_LUI      = 7'b0110111,
        OPC_AUIPC    = 7'b0010111,
        OPC_JAL      = 7'b1101111,
        OPC_JALR     = 7'b1100111,
        OPC_BRANCH   = 7'b1100011,
        OPC_LOAD     = 7'b0000011,
        OPC_STORE    = 7'b0100011,
        OPC_OP_IMM   = 7'b0010011,
        OPC_OP       = 7'b0110011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef enum logic [2:0] {
        F3_ADDI = 3'd0, F3_SLLI = 3'd1, F3_SLTI = 3'd2, F3_SLTIU = 3'd3,
        F3_XORI = 3'd4, F3_SRXI = 3'd5, F3_ORI  = 3'd6, F3_ANDI  = 3'd7
    } opimm_f3_e;

    typedef enum logic [2:0] {
        F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3,
        F3_XOR = 3'd4, F3_SRX = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7
    } op_f3_e;

    typedef enum logic [2:0] {
        F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT  = 3'd4,
        F3_BGE = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7
    } branch_f3_e;

    typedef enum logic [2:0] {
        F3_LB = 3'd0, F3_LH = 3'd1, F3_LW = 3'd2, F3_LBU = 3'd4, F3_LHU = 3'd5
    } load_f3_e;

    typedef enum logic [2:0] {
        F3_SB = 3'd0, F3_SH = 3'd1, F3_SW = 3'd2
    } store_f3_e;

    typedef enum logic [2:0] {
        S_BOOT, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
    } seq_state_e;

    // Instruction class latched in DECODE; NOP must stay zero (reset value).
    typedef enum logic [3:0] {
        CLS_NOP, CLS_ALU, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
        CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_SYSTEM, CLS_ILLEGAL
    } iclass_e;

    localparam logic [3:0] CAUSE_FETCH_FAULT = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT  = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
    localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;
    localparam logic [3:0] CAUSE_ECALL       = 4'd11;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JALR   = 2'd2;
    localparam logic [1:0] PC_TRAP   = 2'd3;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_UIMM = 2'd3;

    // Map the IR fields to an instruction class; any high register-index bit is illegal on RV32E.
    function automatic iclass_e classify(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic [2:0] msb);
        iclass_e c;
        c = CLS_ILLEGAL;
        case (opc)
            OPC_LUI:      c = CLS_LUI;
            OPC_AUIPC:    c = CLS_AUIPC;
            OPC_JAL:      c = CLS_JAL;
            OPC_JALR:     c = CLS_JALR;
            OPC_BRANCH:   c = CLS_BRANCH;
            OPC_OP_IMM,
            OPC_OP:       c = CLS_ALU;
            OPC_LOAD:     if (f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}) c = CLS_LOAD;
            OPC_STORE:    if (f3 inside {F3_SB, F3_SH, F3_SW}) c = CLS_STORE;
            OPC_MISC_MEM: c = CLS_NOP;
            OPC_SYSTEM:   c = CLS_SYSTEM;
            default:      c = CLS_ILLEGAL;
        endcase
        if (msb != 3'b000) c = CLS_ILLEGAL;
        return c;
    endfunction

endpackage

// File: rtl/core_sequencer_timer.sv
// mem_request_timer: watches one memory request and reports a clean ack or an error
// (ack with fault, or MEM_TIMEOUT cycles without ack). MEM_TIMEOUT=0 disables the timeout.
module mem_request_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_req,
    input  logic i_ack,
    input  logic i_fault,
    output logic o_ok,
    output logic o_err
);
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_timeout;

    // An ack in the same cycle as the limit wins over the timeout.
    assign w_timeout = (MEM_TIMEOUT != 0) && i_req && !i_ack && (r_cnt == CW'(MEM_TIMEOUT));
    assign o_ok      = i_req && i_ack && !i_fault;
    assign o_err     = (i_req && i_ack && i_fault) || w_timeout;

    // Wait counter: every request state is entered from a non-request state,
    // so holding it at zero while idle clears it on entry to FETCH or MEM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (!i_req)
            r_cnt <= '0;
        else if (!i_ack && (r_cnt != CW'(MEM_TIMEOUT)))
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle BOOT/FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP control FSM.
// Macro ILLEGAL_TRAP_EN: illegal encodings trap (cause 2); otherwise they retire as NOPs.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [2:0] reg_idx_msb,
    input  logic       sys_ebreak,
    input  logic       branch_taken,
    input  logic       mem_ack,
    input  logic       mem_fault,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] mem_size,
    output logic       ir_load,
    output logic       pc_en,
    output logic [1:0] pc_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       trap,
    output logic [3:0] trap_cause
);
    seq_state_e r_state, w_next;
    iclass_e    r_cls, w_dec_cls;
    logic [1:0] r_size;
    logic       r_taken;
    logic [3:0] r_cause, w_cause;
    logic       w_cause_we;
    logic       w_req, w_ok, w_err;

    // Request depends only on state, so the reset drops it asynchronously.
    assign w_req      = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_dec_cls  = classify(opcode, funct3, reg_idx_msb);
    assign trap_cause = r_cause;

    mem_request_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   (w_req),
        .i_ack   (mem_ack),
        .i_fault (mem_fault),
        .o_ok    (w_ok),
        .o_err   (w_err)
    );

    // State register and trap cause, captured on the transition into TRAP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_BOOT;
            r_cause <= '0;
        end else begin
            r_state <= w_next;
            if (w_cause_we) r_cause <= w_cause;
        end
    end

    // Per-instruction context: class and access size from DECODE, branch outcome from EXECUTE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cls   <= CLS_NOP;
            r_size  <= '0;
            r_taken <= 1'b0;
        end else begin
            if (r_state == S_DECODE) begin
                r_cls  <= w_dec_cls;
                r_size <= funct3[1:0];
            end
            if (r_state == S_EXECUTE) r_taken <= branch_taken;
        end
    end

    // Next-state and output decode from state plus latched class.
    always_comb begin
        w_next     = r_state;
        mem_req    = w_req;
        mem_we     = 1'b0;
        mem_size   = 2'd0;
        ir_load    = 1'b0;
        pc_en      = 1'b0;
        pc_sel     = PC_PLUS4;
        rf_we      = 1'b0;
        wb_sel     = WB_ALU;
        retire     = 1'b0;
        trap       = 1'b0;
        w_cause    = r_cause;
        w_cause_we = 1'b0;
        case (r_state)
            S_BOOT: w_next = S_FETCH;
            S_FETCH: begin
                mem_size = 2'd2;
                if (w_ok) begin
                    ir_load = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_err) begin
                    w_cause    = CAUSE_FETCH_FAULT;
                    w_cause_we = 1'b1;
                    w_next     = S_TRAP;
                end
            end
            S_DECODE: begin
                case (w_dec_cls)
                    CLS_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
                        w_cause    = CAUSE_ILLEGAL;
                        w_cause_we = 1'b1;
                        w_next     = S_TRAP;
`else
                        w_next     = S_WRITEBACK;
`endif
                    end
                    CLS_SYSTEM: begin
                        w_cause    = sys_ebreak ? CAUSE_BREAKPOINT : CAUSE_ECALL;
                        w_cause_we = 1'b1;
                        w_next     = S_TRAP;
                    end
                    default: w_next = S_EXECUTE;
                endcase
            end
            S_EXECUTE: w_next = (r_cls == CLS_LOAD || r_cls == CLS_STORE) ? S_MEM : S_WRITEBACK;
            S_MEM: begin
                mem_we   = (r_cls == CLS_STORE);
                mem_size = r_size;
                if (w_ok) begin
                    w_next = S_WRITEBACK;
                end else if (w_err) begin
                    w_cause    = (r_cls == CLS_STORE) ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                    w_cause_we = 1'b1;
                    w_next     = S_TRAP;
                end
            end
            S_WRITEBACK: begin
                pc_en  = 1'b1;
                retire = 1'b1;
                w_next = S_FETCH;
                case (r_cls)
                    CLS_ALU, CLS_AUIPC: rf_we = 1'b1;
                    CLS_LUI:    begin rf_we = 1'b1; wb_sel = WB_UIMM; end
                    CLS_JAL:    begin rf_we = 1'b1; wb_sel = WB_PC4; pc_sel = PC_BRANCH; end
                    CLS_JALR:   begin rf_we = 1'b1; wb_sel = WB_PC4; pc_sel = PC_JALR; end
                    CLS_BRANCH: pc_sel = r_taken ? PC_BRANCH : PC_PLUS4;
                    CLS_LOAD:   begin rf_we = 1'b1; wb_sel = WB_LOAD; end
                    default: ;
                endcase
            end
            S_TRAP: begin
                trap   = 1'b1;
                pc_en  = 1'b1;
                pc_sel = PC_TRAP;
                w_next = S_FETCH;
            end
            default: w_next = S_BOOT;
        endcase
    end

endmodule
